// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encodings and requester payload types
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   localparam int ALU_ARB_MAX_REQ = 8;

   typedef struct packed {
      alu_op_t            op;
      logic signed [31:0] opr_a;
      logic signed [31:0] opr_b;
   } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bus between requesters and the ALU arbiter
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   alu_op_t                  req_op    [NUM_REQ];
   logic signed [DATA_W-1:0] req_opr_a [NUM_REQ];
   logic signed [DATA_W-1:0] req_opr_b [NUM_REQ];
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [DATA_W-1:0]        rsp_result;

   modport master (
      output req_valid, req_op, req_opr_a, req_opr_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result
   );

   modport slave (
      input  req_valid, req_op, req_opr_a, req_opr_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result
   );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU; shifts use the full opr_b, unknown ops return 0
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  alu_op_t                  i_op,
   input  logic signed [DATA_W-1:0] i_opr_a,
   input  logic signed [DATA_W-1:0] i_opr_b,
   output logic [DATA_W-1:0]        o_result
);
   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_ADD:  o_result = i_opr_a + i_opr_b;
         ALU_SUB:  o_result = i_opr_a - i_opr_b;
         ALU_SLL:  o_result = i_opr_a << $unsigned(i_opr_b);
         ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, (i_opr_a < i_opr_b)};
         ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, ($unsigned(i_opr_a) < $unsigned(i_opr_b))};
         ALU_XOR:  o_result = i_opr_a ^ i_opr_b;
         ALU_SRL:  o_result = $unsigned(i_opr_a) >> $unsigned(i_opr_b);
         ALU_SRA:  o_result = i_opr_a >>> $unsigned(i_opr_b);
         ALU_OR:   o_result = i_opr_a | i_opr_b;
         ALU_AND:  o_result = i_opr_a & i_opr_b;
         default:  o_result = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter_rr.sv
// rtl/alu_arbiter_rr.sv - combinational round-robin grant search starting at i_ptr
module rr_arbiter #(
   parameter int N    = 2,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [N-1:0]    o_grant,
   output logic [ID_W-1:0] o_grant_idx,
   output logic            o_any_grant
);
   always_comb begin
      logic [ID_W-1:0] w_idx;
      o_grant     = '0;
      o_grant_idx = '0;
      o_any_grant = 1'b0;
      w_idx       = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = ID_W'((int'(i_ptr) + k) % N);
         if (!o_any_grant && i_req[w_idx]) begin
            o_any_grant    = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with a registered, tagged response
// Optional per-requester grant/stall counters: ALU_ARBITER_STATS_EN
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus
`ifdef ALU_ARBITER_STATS_EN
   ,
   output logic [31:0]   grant_cnt [NUM_REQ],
   output logic [31:0]   stall_cnt [NUM_REQ]
`endif
);
   logic                     r_rsp_valid;
   logic [ID_W-1:0]          r_rsp_id;
   logic [DATA_W-1:0]        r_rsp_result;
   logic [ID_W-1:0]          r_rr_ptr;

   logic [NUM_REQ-1:0]       w_grant;
   logic [ID_W-1:0]          w_grant_idx;
   logic                     w_any_grant;
   logic                     w_can_accept;
   logic                     w_fire;
   logic [ID_W-1:0]          w_next_ptr;
   alu_op_t                  w_op;
   logic signed [DATA_W-1:0] w_opr_a;
   logic signed [DATA_W-1:0] w_opr_b;
   logic [DATA_W-1:0]        w_alu_result;

   rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .i_req       (bus.req_valid),
      .i_ptr       (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any_grant (w_any_grant)
   );

   assign w_can_accept  = !r_rsp_valid || bus.rsp_ready;
   assign w_fire        = w_any_grant && w_can_accept;
   // Grant never looks at req_ready; readiness is only masked by output space and reset.
   assign bus.req_ready = w_grant & {NUM_REQ{w_can_accept && !rst}};

   assign w_op       = bus.req_op[w_grant_idx];
   assign w_opr_a    = bus.req_opr_a[w_grant_idx];
   assign w_opr_b    = bus.req_opr_b[w_grant_idx];
   assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

   alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_op     (w_op),
      .i_opr_a  (w_opr_a),
      .i_opr_b  (w_opr_b),
      .o_result (w_alu_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rr_ptr     <= '0;
      end else if (w_fire) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_grant_idx;
         r_rsp_result <= w_alu_result;
         r_rr_ptr     <= w_next_ptr;
      end else if (bus.rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_result = r_rsp_result;

`ifdef ALU_ARBITER_STATS_EN
   logic [31:0] r_grant_cnt [NUM_REQ];
   logic [31:0] r_stall_cnt [NUM_REQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_grant_cnt[i] <= '0;
            r_stall_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i])
               r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
            if (bus.req_valid[i] && !bus.req_ready[i])
               r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
         end
      end
   end

   assign grant_cnt = r_grant_cnt;
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter with a queue-based reference model
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ = 2;
   localparam int DW   = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) ifc ();

`ifdef ALU_ARBITER_STATS_EN
   logic [31:0] grant_cnt [NREQ];
   logic [31:0] stall_cnt [NREQ];
`endif

   alu_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc.slave)
`ifdef ALU_ARBITER_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   // requester protocol: a pending request is never withdrawn
   assert property (@(posedge clk) disable iff (rst) (ifc.req_valid[0] && !ifc.req_ready[0]) |=> ifc.req_valid[0]);
   assert property (@(posedge clk) disable iff (rst) (ifc.req_valid[1] && !ifc.req_ready[1]) |=> ifc.req_valid[1]);

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   op_t          rq0 [$];
   op_t          rq1 [$];
   bit           rdy_pat [$];
   int           log_id [$];
   logic [31:0]  log_res [$];

   int           m_ptr;
   bit           m_vld;
   int           m_id;
   logic [31:0]  m_res;
   int           m_grants [NREQ];
   int           m_stalls [NREQ];

   int nchk = 0;
   int nerr = 0;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return (b > 32'd31) ? 32'd0 : a << b[4:0];
         ALU_SRL:  return (b > 32'd31) ? 32'd0 : a >> b[4:0];
         ALU_SRA:  return (b > 32'd31) ? {32{a[31]}} : 32'(sa >>> b[4:0]);
         ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  return a ^ b;
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic op_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      op_t o;
      o.op = op;
      o.a  = a;
      o.b  = b;
      return o;
   endfunction

   function automatic bit has(input int r);
      return (r == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
   endfunction

   function automatic op_t front(input int r);
      return (r == 0) ? rq0[0] : rq1[0];
   endfunction

   task automatic pop(input int r);
      if (r == 0) void'(rq0.pop_front());
      else        void'(rq1.pop_front());
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_vld = 1'b0;
      m_id  = 0;
      m_res = '0;
      for (int i = 0; i < NREQ; i++) begin
         m_grants[i] = 0;
         m_stalls[i] = 0;
      end
   endtask

   task automatic apply_reset();
      ifc.req_valid = '0;
      ifc.rsp_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
   endtask

   // one loop iteration is one clock: drive at edge+1, check ready, clock, check response
   task automatic run_engine(input int max_fires, input int min_cyc);
      int         fires, cyc, eg, idx;
      bit         rdy, acc;
      logic [1:0] v, exp_ready;
      op_t        o;
      fires = 0;
      cyc   = 0;
      while ((((has(0) || has(1)) && (max_fires == 0 || fires < max_fires)) || cyc < min_cyc) && cyc < 4000) begin
         v = {has(1), has(0)};
         for (int r = 0; r < NREQ; r++) begin
            ifc.req_valid[r] = v[r];
            if (v[r]) begin
               o = front(r);
               ifc.req_op[r]    = alu_op_t'(o.op);
               ifc.req_opr_a[r] = o.a;
               ifc.req_opr_b[r] = o.b;
            end
         end
         rdy = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
         ifc.rsp_ready = rdy;
         #1;
         eg = -1;
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (eg < 0 && v[idx]) eg = idx;
         end
         acc = !m_vld || rdy;
         exp_ready = (eg >= 0 && acc) ? 2'(1 << eg) : 2'b00;
         nchk++;
         if (ifc.req_ready !== exp_ready) begin
            nerr++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, ifc.req_ready, exp_ready);
         end
         for (int r = 0; r < NREQ; r++)
            if (v[r] && !exp_ready[r]) m_stalls[r]++;
         @(posedge clk); #1;
         if (exp_ready != 2'b00) begin
            o     = front(eg);
            m_res = ref_alu(o.op, o.a, o.b);
            m_id  = eg;
            m_vld = 1'b1;
            m_ptr = (eg + 1) % NREQ;
            pop(eg);
            fires++;
            m_grants[eg]++;
            log_id.push_back(int'(ifc.rsp_id));
            log_res.push_back(ifc.rsp_result);
         end else if (rdy) begin
            m_vld = 1'b0;
         end
         nchk++;
         if (ifc.rsp_valid !== m_vld) begin
            nerr++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, ifc.rsp_valid, m_vld);
         end
         if (m_vld) begin
            nchk++;
            if (ifc.rsp_id !== 1'(m_id)) begin
               nerr++;
               $display("FAIL rsp_id cyc=%0d got=%0d exp=%0d", cyc, ifc.rsp_id, m_id);
            end
            nchk++;
            if (ifc.rsp_result !== m_res) begin
               nerr++;
               $display("FAIL rsp_result cyc=%0d got=%h exp=%h", cyc, ifc.rsp_result, m_res);
            end
         end
         cyc++;
      end
      if (cyc >= 4000) begin
         nerr++;
         $display("FAIL engine_timeout cycles=%0d limit=4000", cyc);
      end
      rdy_pat.delete();
   endtask

   task automatic check_log(input string name, input int i, input int exp_id, input logic [31:0] exp_res);
      nchk++;
      if (log_id.size() <= i) begin
         nerr++;
         $display("FAIL %s missing response %0d got=%0d responses", name, i, log_id.size());
      end else if (log_id[i] !== exp_id || log_res[i] !== exp_res) begin
         nerr++;
         $display("FAIL %s[%0d] got id=%0d res=%h exp id=%0d res=%h", name, i, log_id[i], log_res[i], exp_id, exp_res);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc.req_valid = 2'b11;
      ifc.rsp_ready = 1'b1;
      for (int r = 0; r < NREQ; r++) begin
         ifc.req_op[r]    = ALU_ADD;
         ifc.req_opr_a[r] = 32'd1;
         ifc.req_opr_b[r] = 32'd2;
      end
      repeat (2) @(posedge clk);
      #1;
      nchk++; if (ifc.rsp_valid !== 1'b0)   begin nerr++; $display("FAIL reset_rsp_valid got=%b exp=0", ifc.rsp_valid); end
      nchk++; if (ifc.rsp_id !== 1'b0)      begin nerr++; $display("FAIL reset_rsp_id got=%0d exp=0", ifc.rsp_id); end
      nchk++; if (ifc.rsp_result !== 32'd0) begin nerr++; $display("FAIL reset_rsp_result got=%h exp=0", ifc.rsp_result); end
      nchk++; if (ifc.req_ready !== 2'b00)  begin nerr++; $display("FAIL reset_req_ready got=%b exp=00", ifc.req_ready); end
      @(negedge clk);
      rst = 1'b0;
      ifc.req_valid = '0;
      @(posedge clk); #1;
      model_reset();
      nchk++; if (ifc.rsp_valid !== 1'b0)   begin nerr++; $display("FAIL post_reset_rsp_valid got=%b exp=0", ifc.rsp_valid); end
   endtask

   task automatic test_single();
      log_id.delete(); log_res.delete();
      rq0.push_back(mk(ALU_ADD, 32'd5, 32'hFFFF_FFFD));
      run_engine(0, 0);
      check_log("single_add", 0, 0, 32'd2);
   endtask

   task automatic test_contention();
      apply_reset();
      log_id.delete(); log_res.delete();
      for (int i = 0; i < 4; i++) begin
         rq0.push_back(mk(ALU_SUB,  32'd10,        32'd4));
         rq1.push_back(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'd1));
      end
      run_engine(0, 0);
      for (int i = 0; i < 8; i++)
         check_log("contention", i, i % 2, (i % 2 == 0) ? 32'd6 : 32'd0);
   endtask

   task automatic test_backpressure();
      log_id.delete(); log_res.delete();
      rq0.push_back(mk(ALU_SLT, 32'hFFFF_FFFF, 32'd1));
      rq0.push_back(mk(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0));
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      run_engine(0, 0);
      check_log("bp_slt", 0, 0, 32'd1);
      check_log("bp_xor", 1, 0, 32'h0000_FF00);
   endtask

   task automatic test_reset_mid_op();
      log_id.delete(); log_res.delete();
      rq0.push_back(mk(ALU_SRA, 32'h8000_0000, 32'd4));
      run_engine(0, 0);
      check_log("sra", 0, 0, 32'hF800_0000);
      ifc.rsp_ready = 1'b0;
      ifc.req_valid = 2'b11;
      for (int r = 0; r < NREQ; r++) begin
         ifc.req_op[r]    = ALU_ADD;
         ifc.req_opr_a[r] = 32'd3;
         ifc.req_opr_b[r] = 32'd3;
      end
      #2;
      rst = 1'b1;
      #1;
      nchk++; if (ifc.rsp_valid !== 1'b0)   begin nerr++; $display("FAIL async_rst_rsp_valid got=%b exp=0", ifc.rsp_valid); end
      nchk++; if (ifc.rsp_result !== 32'd0) begin nerr++; $display("FAIL async_rst_rsp_result got=%h exp=0", ifc.rsp_result); end
      nchk++; if (ifc.req_ready !== 2'b00)  begin nerr++; $display("FAIL async_rst_req_ready got=%b exp=00", ifc.req_ready); end
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      nchk++; if (ifc.req_ready !== 2'b00)  begin nerr++; $display("FAIL in_rst_req_ready got=%b exp=00", ifc.req_ready); end
      nchk++; if (ifc.rsp_valid !== 1'b0)   begin nerr++; $display("FAIL in_rst_rsp_valid got=%b exp=0", ifc.rsp_valid); end
      @(negedge clk);
      rst = 1'b0;
      ifc.req_valid = '0;
      @(posedge clk); #1;
      model_reset();
      log_id.delete(); log_res.delete();
      rq0.push_back(mk(ALU_ADD, 32'd7, 32'd8));
      rq1.push_back(mk(ALU_ADD, 32'd1, 32'd1));
      run_engine(0, 0);
      check_log("post_rst_first", 0, 0, 32'd15);
      check_log("post_rst_second", 1, 1, 32'd2);
   endtask

   task automatic test_idle_invalid();
      rq0.push_back(mk(ALU_ADD, 32'd1, 32'd1));
      run_engine(0, 0);
      run_engine(0, 3);
      nchk++; if (ifc.rsp_valid !== 1'b0) begin nerr++; $display("FAIL idle_rsp_valid got=%b exp=0", ifc.rsp_valid); end
      log_id.delete(); log_res.delete();
      rq0.push_back(mk(ALU_ADD, 32'd2, 32'd2));
      rq1.push_back(mk(4'hC, $urandom(), $urandom()));
      run_engine(0, 0);
      check_log("invalid_op", 0, 1, 32'd0);
      check_log("after_invalid", 1, 0, 32'd4);
   endtask

   task automatic test_random();
      int n0, n1;
      logic [31:0] b;
      n0 = $urandom_range(20, 40);
      n1 = $urandom_range(20, 40);
      for (int i = 0; i < n0 + n1; i++) begin
         b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
         if (i < n0) rq0.push_back(mk(4'($urandom_range(0, 11)), $urandom(), b));
         else        rq1.push_back(mk(4'($urandom_range(0, 11)), $urandom(), b));
      end
      for (int i = 0; i < 300; i++)
         rdy_pat.push_back($urandom_range(0, 9) < 7);
      run_engine(0, 0);
   endtask

`ifdef ALU_ARBITER_STATS_EN
   task automatic test_stats();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         rq0.push_back(mk(ALU_SUB,  32'd10,        32'd4));
         rq1.push_back(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'd1));
      end
      run_engine(6, 0);
      for (int i = 0; i < NREQ; i++) begin
         nchk++; if (grant_cnt[i] !== 32'd3) begin nerr++; $display("FAIL stats_grant[%0d] got=%0d exp=3", i, grant_cnt[i]); end
         nchk++; if (stall_cnt[i] !== 32'd3) begin nerr++; $display("FAIL stats_stall[%0d] got=%0d exp=3", i, stall_cnt[i]); end
      end
      run_engine(0, 0);
      for (int i = 0; i < NREQ; i++) begin
         nchk++; if (grant_cnt[i] !== 32'(m_grants[i])) begin nerr++; $display("FAIL stats_grant_end[%0d] got=%0d exp=%0d", i, grant_cnt[i], m_grants[i]); end
         nchk++; if (stall_cnt[i] !== 32'(m_stalls[i])) begin nerr++; $display("FAIL stats_stall_end[%0d] got=%0d exp=%0d", i, stall_cnt[i], m_stalls[i]); end
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      test_idle_invalid();
      test_random();
`ifdef ALU_ARBITER_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (op/opr_a/opr_b -> opr_result) between NUM_REQ requesters, e.g. the integer pipe and the branch/address unit.
- Arbitration is round-robin. Each requester hands over its operation on a valid/ready request channel.
- Each granted operation is evaluated in one cycle. Its result is registered and returned on a single valid/ready response channel, tagged with the requester index.
- Sits inside ex_stage, in front of the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ x alu_op_t  per-requester ALU operation.
- req_opr_a  in  NUM_REQ x DATA_W  per-requester operand A, signed.
- req_opr_b  in  NUM_REQ x DATA_W  per-requester operand B, signed.
- rsp_valid  out  1  result held in output register.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of requester that owns rsp_result.
- rsp_result  out  DATA_W  registered ALU result.

Behaviour:
- Reset (asynchronous, active-high): rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0, req_ready=0.
  - Reset asserted mid-operation discards any held result.
  - No request is accepted while rst=1.
- can_accept = !rsp_valid || rsp_ready.
- Grant:
  - Combinational, round-robin. Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets the grant.
  - grant depends only on req_valid and rr_ptr, never on req_ready.
  - req_ready[i] = grant[i] && can_accept.
- Transfer: a request fires when req_valid[i] && req_ready[i]. On that clock edge:
  - rsp_result <= ALU(req_op[i], req_opr_a[i], req_opr_b[i]).
  - rsp_id <= i.
  - rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from request fire to rsp_valid. Throughput: 1 op/cycle when rsp_ready is held high.
- Response hold: while rsp_valid && !rsp_ready, rsp_result/rsp_id stay stable and every req_ready is 0.
- Simultaneous pop and push: rsp_valid && rsp_ready with a new request firing -> the register reloads and rsp_valid stays 1 with no bubble.
- Pop only: rsp_valid && rsp_ready with no request firing -> rsp_valid <= 0.
- No request valid: rr_ptr unchanged.
- Requester rules:
  - Once req_valid[i] is asserted, it holds req_valid[i] and its payload stable until req_ready[i].
  - A withdrawn request is a protocol violation, covered by a bench assertion.
- Arithmetic:
  - The ALU is evaluated as defined: signed SLT, unsigned SLTU, shifts by full opr_b.
  - The arbiter passes operands unmodified.
  - Unknown op gives result 0.
- Fairness: with all requesters valid every cycle, each is granted once per NUM_REQ accepted transfers.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- When defined, adds per-requester output ports:
  - grant_cnt, NUM_REQ x 32: counts fired requests.
  - stall_cnt, NUM_REQ x 32: counts cycles with req_valid[i] && !req_ready[i].
  - Both reset to 0, wrap at 2^32, no saturation.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- alu_pkg holds:
  - alu_op_t (existing).
  - localparam ALU_ARB_MAX_REQ = 8.
  - A packed alu_req_t struct {alu_op_t op; logic signed [31:0] opr_a, opr_b;} for requester payloads.
- One sub-module is natural: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant[N], grant_idx, any_grant.
  - Purely combinational; rr_ptr itself stays in alu_arbiter.
- The ALU is instantiated once inside alu_arbiter.

Test Plan:
- Single requester: req0 ADD, a=5, b=-3, rsp_ready=1 -> req_ready[0]=1 same cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_result=2.
- Contention: both valid every cycle, rsp_ready=1, rr_ptr=0 at start.
  - Req0 SUB, a=10, b=4; req1 SLTU, a=-1, b=1.
  - Grants alternate 0,1,0,1, giving results 6,0 alternating.
- Backpressure: rsp_ready=0 after the first result (SLT, a=-1, b=1 -> 1).
  - rsp_result stays 1 and req_ready stays 0 for 4 cycles.
  - On rsp_ready=1 the next op (XOR 0xF0F0 ^ 0x0FF0 = 0xFF00) loads with no bubble.
- Reset mid-op: assert rst while rsp_valid=1 holding SRA (0x80000000 >>> 4 = 0xF8000000).
  - rsp_valid drops immediately (asynchronous).
  - After release, rr_ptr=0 and the first grant goes to req0.
- Idle and invalid op:
  - No valid for 3 cycles -> rr_ptr unchanged, rsp_valid=0.
  - Then an undefined op encoding on req1 -> rsp_result=0, rsp_id=1.
- Stats (with ALU_ARBITER_STATS_EN): 6 contended transfers with rsp_ready=1 -> grant_cnt={3,3}, stall_cnt={3,3}.
